mips_multicycle_cu: RTL and testbench

// Multicycle MIPS control unit: next-generation replacement for the single-cycle combinational CU. FSM sequences

---
 rtl/mips_multicycle_cu.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mips_multicycle_cu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_cu.sv
// mips_multicycle_cu
//   Multicycle MIPS control unit. It steps each instruction through fetch,
//   decode, execute, memory and writeback, and all of these share one memory
//   port that uses a ready handshake. The unit also provides a memory-wait
//   timeout, an illegal-opcode trap and a retired-instruction counter.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   opcode       instr[31:26] from the datapath IR; valid from DECODE onwards
//   mem_ready    memory finished the current read/write in this cycle
//   pc_write     unconditional PC load
//   pc_write_eq  PC load if the ALU result is zero (beq)
//   pc_write_ne  PC load if the ALU result is non-zero (bne)
//   iord         memory address source: 0 = PC, 1 = ALUOut
//   mem_read     memory read request (level)
//   mem_write    memory write request (level)
//   ir_write     instruction register load
//   reg_write    register file write enable
//   reg_dst      destination register: 0 = rt, 1 = rd, 2 = $31
//   mem_to_reg   write-back source: 0 = ALUOut, 1 = MDR, 2 = PC
//   alu_src_a    ALU A operand: 0 = PC, 1 = rs
//   alu_src_b    ALU B operand: 0 = rt, 1 = 4, 2 = simm, 3 = simm<<2
//   alu_op       0 = add, 1 = sub, 2 = funct, 3 = and
//   pc_src       PC source: 0 = ALU, 1 = ALUOut, 2 = jump target
//   instr_done   one-cycle pulse when an instruction retires
//   instret      count of retired instructions; wraps to zero
//   trap         sticky: illegal opcode or memory timeout
//   trap_cause   0 = illegal opcode, 1 = memory timeout
module mips_multicycle_cu #(
  parameter int unsigned OPC_W       = 6,
  parameter int unsigned TMO_W       = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_eq,
  output logic             pc_write_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic             trap_cause
);

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'h00);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'h02);
  localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'(6'h03);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'h04);
  localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(6'h05);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'h08);
  localparam logic [OPC_W-1:0] OP_ANDI  = OPC_W'(6'h0C);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'h23);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'h2B);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    WB_R,
    EXEC_ADDI,
    EXEC_ANDI,
    WB_I,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    BEQ,
    BNE,
    JUMP,
    JAL,
    TRAP
  } state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               trap_cause_q, trap_cause_d;
  logic               is_store_q, is_store_d;

  logic               mem_state;
  logic               timeout;

  // Memory-wait bookkeeping is shared by the three states that own the port.
  // A ready in the cycle that would time out still counts as completion.
  always_comb begin
    mem_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    timeout   = (MEM_TIMEOUT != 0) && (wait_q == TMO_W'(MEM_TIMEOUT)) && !mem_ready;
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    trap_cause_d = trap_cause_q;
    wait_d       = '0;
    instret_d    = instr_done ? instret_q + CNT_W'(1) : instret_q;

    if (mem_state && !mem_ready && !timeout) begin
      wait_d = wait_q + TMO_W'(1);
    end

    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else if (timeout) begin
          state_d      = TRAP;
          trap_cause_d = 1'b1;
        end
      end
      DECODE: begin
        is_store_d = (opcode == OP_SW);
        case (opcode)
          OP_RTYPE:     state_d = EXEC_R;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BEQ;
          OP_BNE:       state_d = BNE;
          OP_J:         state_d = JUMP;
          OP_JAL:       state_d = JAL;
          OP_ADDI:      state_d = EXEC_ADDI;
          OP_ANDI:      state_d = EXEC_ANDI;
          default: begin
            state_d      = TRAP;
            trap_cause_d = 1'b0;
          end
        endcase
      end
      EXEC_R:    state_d = WB_R;
      EXEC_ADDI: state_d = WB_I;
      EXEC_ANDI: state_d = WB_I;
      MEM_ADDR:  state_d = is_store_q ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready) begin
          state_d = MEM_WB;
        end else if (timeout) begin
          state_d      = TRAP;
          trap_cause_d = 1'b1;
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_d = FETCH;
        end else if (timeout) begin
          state_d      = TRAP;
          trap_cause_d = 1'b1;
        end
      end
      WB_R, WB_I, MEM_WB, BEQ, BNE, JUMP, JAL: state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      wait_q       <= '0;
      instret_q    <= '0;
      trap_cause_q <= 1'b0;
      is_store_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      instret_q    <= instret_d;
      trap_cause_q <= trap_cause_d;
      is_store_q   <= is_store_d;
    end
  end

  // Moore decode of the state register. The reset state is FETCH, but FETCH
  // drives mem_read, so the decode is gated by rst to keep every output at
  // zero for as long as reset is held.
  always_comb begin
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_op      = 2'd0;
    pc_src      = 2'd0;
    instr_done  = 1'b0;

    if (rst) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: alu_src_b = 2'd3;
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
        end
        EXEC_ADDI, MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        EXEC_ANDI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = 2'd3;
        end
        WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = 2'd1;
          instr_done = 1'b1;
        end
        WB_I: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        BEQ, BNE: begin
          alu_src_a   = 1'b1;
          alu_op      = 2'd1;
          pc_src      = 2'd1;
          pc_write_eq = (state_q == BEQ);
          pc_write_ne = (state_q == BNE);
          instr_done  = 1'b1;
        end
        JUMP: begin
          pc_src     = 2'd2;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        JAL: begin
          pc_src     = 2'd2;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign instret    = instret_q;
  assign trap       = (state_q == TRAP);
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_mips_multicycle_cu.sv
// tb_mips_multicycle_cu
//   Directed bench for mips_multicycle_cu. The bench runs the unit with
//   CNT_W=4 so that the retire counter can wrap. A reactive memory raises
//   mem_ready after a programmed number of wait cycles. The driver pushes one
//   expected record for each retire or trap, and the monitor pops and
//   compares a record whenever the DUT shows either event.
module tb_mips_multicycle_cu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write;
  logic       ir_write, reg_write, alu_src_a, instr_done, trap, trap_cause;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic [3:0] instret;

  mips_multicycle_cu #(
    .OPC_W(6), .TMO_W(4), .MEM_TIMEOUT(15), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
    .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  logic [18:0] live_ctl;
  assign live_ctl = {pc_write, pc_write_eq, pc_write_ne, reg_write, reg_dst,
                     mem_to_reg, pc_src, alu_op, alu_src_a, alu_src_b,
                     mem_read, mem_write, iord, ir_write};

  function automatic logic [18:0] mk(input bit pw, input bit eq, input bit ne,
                                     input bit rw, input int rdst, input int m2r,
                                     input int psrc, input int aop, input bit asa,
                                     input int asb, input bit mr, input bit mw,
                                     input bit io, input bit irw);
    return {pw, eq, ne, rw, rdst[1:0], m2r[1:0], psrc[1:0], aop[1:0], asa,
            asb[1:0], mr, mw, io, irw};
  endfunction

  typedef struct {
    bit          is_trap;
    int          lat;
    bit          cause;
    logic [3:0]  cnt;
    logic [18:0] ctl;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         fetch_wait = 0;
  int         data_wait = 0;
  logic [3:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reactive memory: wait the programmed number of cycles, then ready for one cycle.
  initial begin
    int mcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_ready = 1'b0;
        mcnt      = 0;
      end else begin
        if (mem_ready) begin
          mem_ready = 1'b0;
          mcnt      = 0;
        end
        if (mem_read || mem_write) begin
          if (mcnt >= (iord ? data_wait : fetch_wait)) mem_ready = 1'b1;
          else mcnt++;
        end
      end
    end
  end

  // Monitor: latency is counted in cycles since reset or since the last retire.
  initial begin
    int   lat = 0;
    bit   trap_seen = 0;
    bit   pend = 0;
    bit   was_fd = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        lat = 0; trap_seen = 0; pend = 0; was_fd = 0;
      end else begin
        lat++;
        if (was_fd)
          chk("decode_ctl", live_ctl, mk(0,0,0,0,0,0,0,0,0,3,0,0,0,0));
        if (mem_read && !iord)
          chk("fetch_ctl", {ir_write, pc_write, alu_src_a, alu_src_b, alu_op, pc_src},
              {mem_ready, mem_ready, 1'b0, 2'd1, 2'd0, 2'd0});
        if (pend && !trap) chk("req_level", mem_read | mem_write, 1);
        pend   = (mem_read || mem_write) && !mem_ready;
        was_fd = mem_read && !iord && mem_ready;
        if (instr_done) begin
          if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_retire: got retire expected none at %0t", $time);
          end else begin
            e = sbq.pop_front();
            chk("event_kind", 0, e.is_trap);
            chk("retire_lat", lat, e.lat);
            chk("retire_ctl", live_ctl, e.ctl);
            chk("instret_pre", instret, e.cnt);
          end
          lat = 0;
        end
        if (trap && !trap_seen) begin
          trap_seen = 1;
          if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_trap: got trap expected none at %0t", $time);
          end else begin
            e = sbq.pop_front();
            chk("event_kind", 1, e.is_trap);
            chk("trap_lat", lat, e.lat);
            chk("trap_cause", trap_cause, e.cause);
            chk("trap_instret", instret, e.cnt);
          end
        end
      end
    end
  end

  task automatic wait_evt(input bit want_trap);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (want_trap ? trap : instr_done) return;
    end
    n_chk++; n_fail++;
    $display("FAIL event_timeout: got no %s expected one", want_trap ? "trap" : "retire");
  endtask

  task automatic issue(input logic [5:0] opc, input int fw, input int dw,
                       input int lat, input logic [18:0] ctl);
    exp_t e;
    opcode = opc; fetch_wait = fw; data_wait = dw;
    e.is_trap = 0; e.lat = lat; e.cause = 0; e.cnt = exp_cnt; e.ctl = ctl;
    sbq.push_back(e);
    exp_cnt++;
    wait_evt(0);
  endtask

  task automatic issue_trap(input logic [5:0] opc, input int fw, input int lat, input bit cause);
    exp_t e;
    opcode = opc; fetch_wait = fw; data_wait = 0;
    e.is_trap = 1; e.lat = lat; e.cause = cause; e.cnt = exp_cnt; e.ctl = '0;
    sbq.push_back(e);
    wait_evt(1);
    repeat (4) @(negedge clk);
    #1;
    chk("trap_sticky", trap, 1);
    chk("trap_cause_hold", trap_cause, cause);
    chk("trap_outputs", {live_ctl, instr_done}, 0);
    chk("trap_instret_frozen", instret, exp_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_cnt = '0;
    #1;
    chk("rst_outputs", {live_ctl, instr_done}, 0);
    chk("rst_instret", instret, 0);
    chk("rst_trap", {trap, trap_cause}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] c_wbr, c_wbi, c_mwb, c_sw, c_beq, c_bne, c_j, c_jal;
    //          pw eq ne rw rd m2r ps aop a  b  mr mw io ir
    c_wbr = mk(0, 0, 0, 1, 1, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    c_wbi = mk(0, 0, 0, 1, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    c_mwb = mk(0, 0, 0, 1, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0);
    c_sw  = mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 1, 1, 0);
    c_beq = mk(0, 1, 0, 0, 0, 0,  1, 1,  1, 0, 0, 0, 0, 0);
    c_bne = mk(0, 0, 1, 0, 0, 0,  1, 1,  1, 0, 0, 0, 0, 0);
    c_j   = mk(1, 0, 0, 0, 0, 0,  2, 0,  0, 0, 0, 0, 0, 0);
    c_jal = mk(1, 0, 0, 1, 2, 2,  2, 0,  0, 0, 0, 0, 0, 0);

    do_reset();
    issue(6'h00, 0, 0, 4,  c_wbr);   // add
    issue(6'h23, 3, 2, 10, c_mwb);   // lw with fetch and data waits
    issue(6'h04, 0, 0, 3,  c_beq);
    issue(6'h05, 0, 0, 3,  c_bne);
    issue(6'h08, 0, 0, 4,  c_wbi);   // addi
    issue(6'h0C, 0, 0, 4,  c_wbi);   // andi
    issue(6'h02, 0, 0, 3,  c_j);
    issue(6'h03, 0, 0, 3,  c_jal);
    issue(6'h2B, 0, 0, 4,  c_sw);
    issue(6'h2B, 1, 2, 7,  c_sw);
    issue(6'h23, 0, 0, 5,  c_mwb);
    issue(6'h00, 2, 0, 6,  c_wbr);
    issue(6'h08, 0, 0, 4,  c_wbi);
    issue(6'h0C, 0, 0, 4,  c_wbi);
    issue(6'h03, 0, 0, 3,  c_jal);
    issue(6'h04, 0, 0, 3,  c_beq);   // 16th retire: counter 15 -> 0
    issue(6'h02, 0, 0, 3,  c_j);     // sees instret 0 after wrap

    issue_trap(6'h3F, 0, 3, 0);      // illegal opcode
    do_reset();
    issue_trap(6'h00, 1000, 17, 1);  // memory timeout in fetch
    do_reset();
    issue(6'h00, 15, 0, 19, c_wbr);  // ready exactly at the timeout count

    // Abort a store in the middle of its memory wait.
    opcode = 6'h2B; fetch_wait = 0; data_wait = 1000;
    begin
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        #1;
        seen = mem_write;
      end
      chk("mem_wr_reached", seen, 1);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    exp_cnt = '0;
    #1;
    chk("abort_outputs", {live_ctl, instr_done}, 0);
    chk("abort_instret", instret, 0);
    chk("abort_trap", trap, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    issue(6'h00, 0, 0, 4, c_wbr);

    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
